// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RISC-V core: opcodes, control encodings
// and the ID/EX register layout. An all-zero id_ex_t is a bubble.
package rv_pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_NREG_W = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Field widths are fixed by the package; the decode stage defaults its parameters to match.
    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic                   alu_src;
        logic                   mem_write;
        logic                   result_src;
        logic                   branch;
        logic [2:0]             alu_control;
        logic [PIPE_XLEN-1:0]   rd1;
        logic [PIPE_XLEN-1:0]   rd2;
        logic [PIPE_XLEN-1:0]   imm_ext;
        logic [PIPE_XLEN-1:0]   pc;
        logic [PIPE_XLEN-1:0]   pc_plus4;
        logic [PIPE_NREG_W-1:0] rd;
        logic [PIPE_NREG_W-1:0] rs1;
        logic [PIPE_NREG_W-1:0] rs2;
    } id_ex_t;

    typedef enum logic [2:0] {
        E_LOAD,
        E_HOLD,
        E_FLUSH,
        E_HAZARD,
        E_IDLE
    } e_action_t;

    function automatic logic counts_bubble(input e_action_t action);
        return (action == E_FLUSH) || (action == E_HAZARD);
    endfunction

endpackage

// File: rtl/control_unit_top.sv
// Main decoder plus ALU decoder for the RV32I subset used by the core
// (loads, stores, R-type, I-type ALU and branches).
module control_unit_top
    import rv_pipe_pkg::*;
(
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       ResultSrc,
    output logic       Branch,
    output logic [2:0] ALUControl
);

    logic [1:0] alu_op;

    always_comb begin
        RegWrite  = 1'b0;
        ImmSrc    = IMM_I;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        ResultSrc = 1'b0;
        Branch    = 1'b0;
        alu_op    = ALUOP_ADD;
        case (Op)
            OP_LOAD: begin
                RegWrite  = 1'b1;
                ALUSrc    = 1'b1;
                ResultSrc = 1'b1;
            end
            OP_STORE: begin
                ImmSrc   = IMM_S;
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_RTYPE: begin
                RegWrite = 1'b1;
                alu_op   = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                alu_op   = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                ImmSrc = IMM_B;
                Branch = 1'b1;
                alu_op = ALUOP_SUB;
            end
            default: ;
        endcase
    end

    // funct7b5 only selects SUB for R-type; addi with a negative immediate must stay ADD.
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (Op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/regfile_bypass.sv
// Register file with two async read ports, one sync write port, hardwired x0
// and write-through bypass so a same-cycle write-back is visible to decode.
module regfile_bypass #(
    parameter int XLEN   = 32,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREG_W-1:0] ra1,
    input  logic [NREG_W-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic              we,
    input  logic [NREG_W-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    localparam int NREGS = 1 << NREG_W;

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    // x0 check comes first so a write-back aimed at x0 can never leak through the bypass.
    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_en && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_en && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/sign_extend.sv
// Immediate generator: rebuilds and sign-extends the I, S or B immediate from the
// upper 25 bits of the instruction word.
module sign_extend
    import rv_pipe_pkg::*;
(
    input  logic [31:7] In,
    input  logic [1:0]  ImmSrc,
    output logic [31:0] Imm_Ext
);

    always_comb begin
        Imm_Ext = '0;
        case (ImmSrc)
            IMM_I:   Imm_Ext = {{20{In[31]}}, In[31:20]};
            IMM_S:   Imm_Ext = {{20{In[31]}}, In[31:25], In[11:7]};
            IMM_B:   Imm_Ext = {{20{In[31]}}, In[7], In[30:25], In[11:8], 1'b0};
            default: Imm_Ext = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage and ID/EX register with stall, flush, load-use bubble insertion,
// write-through register-file bypass and a saturating bubble counter.
module decode_stage_hz
    import rv_pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int NREG_W = PIPE_NREG_W,
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidD,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              RegWriteW,
    input  logic [NREG_W-1:0] RDW,
    input  logic [XLEN-1:0]   ResultW,
    output logic              HazardStallD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              ResultSrcE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1_E,
    output logic [XLEN-1:0]   RD2_E,
    output logic [XLEN-1:0]   Imm_Ext_E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [NREG_W-1:0] RD_E,
    output logic [NREG_W-1:0] RS1_E,
    output logic [NREG_W-1:0] RS2_E,
    output logic [BCNT_W-1:0] BubbleCnt
);

    logic [NREG_W-1:0] rs1_d;
    logic [NREG_W-1:0] rs2_d;
    logic [NREG_W-1:0] rd_d;
    logic              reg_write_d;
    logic [1:0]        imm_src_d;
    logic              alu_src_d;
    logic              mem_write_d;
    logic              result_src_d;
    logic              branch_d;
    logic [2:0]        alu_control_d;
    logic [31:0]       imm32_d;
    logic [XLEN-1:0]   imm_d;
    logic [XLEN-1:0]   rd1_d;
    logic [XLEN-1:0]   rd2_d;

    id_ex_t            d_pkt;
    id_ex_t            e_next;
    id_ex_t            e_q;
    e_action_t         action;
    logic [BCNT_W-1:0] bubble_cnt;

    assign rs1_d = NREG_W'(InstrD[19:15]);
    assign rs2_d = NREG_W'(InstrD[24:20]);
    assign rd_d  = NREG_W'(InstrD[11:7]);

    control_unit_top u_control (
        .Op         (InstrD[6:0]),
        .funct3     (InstrD[14:12]),
        .funct7b5   (InstrD[30]),
        .RegWrite   (reg_write_d),
        .ImmSrc     (imm_src_d),
        .ALUSrc     (alu_src_d),
        .MemWrite   (mem_write_d),
        .ResultSrc  (result_src_d),
        .Branch     (branch_d),
        .ALUControl (alu_control_d)
    );

    sign_extend u_sign_extend (
        .In      (InstrD[31:7]),
        .ImmSrc  (imm_src_d),
        .Imm_Ext (imm32_d)
    );

    assign imm_d = XLEN'($signed(imm32_d));

    regfile_bypass #(
        .XLEN   (XLEN),
        .NREG_W (NREG_W)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1_d),
        .ra2 (rs2_d),
        .rd1 (rd1_d),
        .rd2 (rd2_d),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW)
    );

    // A load in E whose destination feeds the instruction in D cannot be forwarded in time.
    assign HazardStallD = e_q.valid && e_q.result_src && e_q.reg_write && (e_q.rd != '0)
                          && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d)) && ValidD;

    always_comb begin
        d_pkt             = '0;
        d_pkt.valid       = 1'b1;
        d_pkt.reg_write   = reg_write_d;
        d_pkt.alu_src     = alu_src_d;
        d_pkt.mem_write   = mem_write_d;
        d_pkt.result_src  = result_src_d;
        d_pkt.branch      = branch_d;
        d_pkt.alu_control = alu_control_d;
        d_pkt.rd1         = rd1_d;
        d_pkt.rd2         = rd2_d;
        d_pkt.imm_ext     = imm_d;
        d_pkt.pc          = PCD;
        d_pkt.pc_plus4    = PCPlus4D;
        d_pkt.rd          = rd_d;
        d_pkt.rs1         = rs1_d;
        d_pkt.rs2         = rs2_d;
    end

    // Flush beats hold so a taken branch can kill a load stuck behind memory back-pressure.
    always_comb begin
        action = E_LOAD;
        if (FlushE) begin
            action = E_FLUSH;
        end else if (StallE) begin
            action = E_HOLD;
        end else if (HazardStallD) begin
            action = E_HAZARD;
        end else if (!ValidD) begin
            action = E_IDLE;
        end
    end

    always_comb begin
        e_next = '0;
        case (action)
            E_LOAD:  e_next = d_pkt;
            E_HOLD:  e_next = e_q;
            default: e_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (counts_bubble(action) && (bubble_cnt != {BCNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign ValidE      = e_q.valid;
    assign RegWriteE   = e_q.reg_write;
    assign ALUSrcE     = e_q.alu_src;
    assign MemWriteE   = e_q.mem_write;
    assign ResultSrcE  = e_q.result_src;
    assign BranchE     = e_q.branch;
    assign ALUControlE = e_q.alu_control;
    assign RD1_E       = e_q.rd1;
    assign RD2_E       = e_q.rd2;
    assign Imm_Ext_E   = e_q.imm_ext;
    assign PCE         = e_q.pc;
    assign PCPlus4E    = e_q.pc_plus4;
    assign RD_E        = e_q.rd;
    assign RS1_E       = e_q.rs1;
    assign RS2_E       = e_q.rs2;
    assign BubbleCnt   = bubble_cnt;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: reset, bypass, load-use bubble, stall/flush
// priority and counter saturation (second instance built with a 2-bit counter).
module tb_decode_stage_hz;

    localparam logic [31:0] I_ADDI_X5  = 32'h00700293;
    localparam logic [31:0] I_ADD_X8   = 32'h00028433;
    localparam logic [31:0] I_SUB_X9   = 32'h405004B3;
    localparam logic [31:0] I_LW_X6    = 32'h0000A303;
    localparam logic [31:0] I_ADD_X7   = 32'h002303B3;

    logic        clk;
    logic        rst;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        StallE;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;

    logic        HazardStallD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, RS1_E, RS2_E;
    logic [15:0] BubbleCnt;

    logic        sat_HazardStallD, sat_ValidE, sat_RegWriteE, sat_ALUSrcE, sat_MemWriteE;
    logic        sat_ResultSrcE, sat_BranchE;
    logic [2:0]  sat_ALUControlE;
    logic [31:0] sat_RD1_E, sat_RD2_E, sat_Imm_Ext_E, sat_PCE, sat_PCPlus4E;
    logic [4:0]  sat_RD_E, sat_RS1_E, sat_RS2_E;
    logic [1:0]  sat_BubbleCnt;

    int assertCount = 0;
    int failCount   = 0;

    decode_stage_hz dut (
        .clk (clk), .rst (rst), .ValidD (ValidD), .InstrD (InstrD), .PCD (PCD),
        .PCPlus4D (PCPlus4D), .StallE (StallE), .FlushE (FlushE), .RegWriteW (RegWriteW),
        .RDW (RDW), .ResultW (ResultW), .HazardStallD (HazardStallD), .ValidE (ValidE),
        .RegWriteE (RegWriteE), .ALUSrcE (ALUSrcE), .MemWriteE (MemWriteE),
        .ResultSrcE (ResultSrcE), .BranchE (BranchE), .ALUControlE (ALUControlE),
        .RD1_E (RD1_E), .RD2_E (RD2_E), .Imm_Ext_E (Imm_Ext_E), .PCE (PCE),
        .PCPlus4E (PCPlus4E), .RD_E (RD_E), .RS1_E (RS1_E), .RS2_E (RS2_E),
        .BubbleCnt (BubbleCnt)
    );

    decode_stage_hz #(.BCNT_W(2)) dut_sat (
        .clk (clk), .rst (rst), .ValidD (ValidD), .InstrD (InstrD), .PCD (PCD),
        .PCPlus4D (PCPlus4D), .StallE (StallE), .FlushE (FlushE), .RegWriteW (RegWriteW),
        .RDW (RDW), .ResultW (ResultW), .HazardStallD (sat_HazardStallD), .ValidE (sat_ValidE),
        .RegWriteE (sat_RegWriteE), .ALUSrcE (sat_ALUSrcE), .MemWriteE (sat_MemWriteE),
        .ResultSrcE (sat_ResultSrcE), .BranchE (sat_BranchE), .ALUControlE (sat_ALUControlE),
        .RD1_E (sat_RD1_E), .RD2_E (sat_RD2_E), .Imm_Ext_E (sat_Imm_Ext_E), .PCE (sat_PCE),
        .PCPlus4E (sat_PCPlus4E), .RD_E (sat_RD_E), .RS1_E (sat_RS1_E), .RS2_E (sat_RS2_E),
        .BubbleCnt (sat_BubbleCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                                 input logic stall, input logic flush);
        ValidD    = valid;
        InstrD    = instr;
        PCD       = pc;
        PCPlus4D  = pc + 32'd4;
        RegWriteW = rw;
        RDW       = rdw;
        ResultW   = resw;
        StallE    = stall;
        FlushE    = flush;
        #1;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("reset_valid", ValidE, 1'b0);
        checkOutput("reset_pce", PCE, 32'h0);
        checkOutput("reset_cnt", BubbleCnt, 16'd0);
        checkOutput("reset_cnt_sat", sat_BubbleCnt, 2'd0);
        checkOutput("reset_hazard", HazardStallD, 1'b0);
        rst = 1'b0;

        $display("[TB] addi decode and latency");
        applyStimulus(1'b1, I_ADDI_X5, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("addi_hazard", HazardStallD, 1'b0);
        stepClk();
        checkOutput("addi_valid", ValidE, 1'b1);
        checkOutput("addi_regwrite", RegWriteE, 1'b1);
        checkOutput("addi_alusrc", ALUSrcE, 1'b1);
        checkOutput("addi_resultsrc", ResultSrcE, 1'b0);
        checkOutput("addi_aluctl", ALUControlE, 3'b000);
        checkOutput("addi_imm", Imm_Ext_E, 32'd7);
        checkOutput("addi_rd", RD_E, 5'd5);
        checkOutput("addi_rs2", RS2_E, 5'd7);
        checkOutput("addi_pc", PCE, 32'h100);
        checkOutput("addi_pc4", PCPlus4E, 32'h104);

        $display("[TB] write-through bypass and x0");
        applyStimulus(1'b1, I_ADD_X8, 32'h104, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
        stepClk();
        checkOutput("bypass_rd1", RD1_E, 32'h1234);
        checkOutput("bypass_rd2", RD2_E, 32'h0);
        checkOutput("bypass_alusrc", ALUSrcE, 1'b0);
        checkOutput("bypass_rd", RD_E, 5'd8);
        checkOutput("bypass_rs1", RS1_E, 5'd5);
        applyStimulus(1'b1, I_SUB_X9, 32'h108, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        stepClk();
        checkOutput("x0_bypass_rd1", RD1_E, 32'h0);
        checkOutput("x5_stored_rd2", RD2_E, 32'h1234);
        checkOutput("sub_aluctl", ALUControlE, 3'b001);
        applyStimulus(1'b1, I_SUB_X9, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("x0_later_rd1", RD1_E, 32'h0);

        $display("[TB] load-use hazard");
        applyStimulus(1'b1, I_LW_X6, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("lw_hazard_pre", HazardStallD, 1'b0);
        stepClk();
        checkOutput("lw_resultsrc", ResultSrcE, 1'b1);
        checkOutput("lw_alusrc", ALUSrcE, 1'b1);
        checkOutput("lw_rd", RD_E, 5'd6);
        applyStimulus(1'b1, I_ADD_X7, 32'h114, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        checkOutput("lu_hazard", HazardStallD, 1'b1);
        stepClk();
        checkOutput("lu_bubble_valid", ValidE, 1'b0);
        checkOutput("lu_bubble_pc", PCE, 32'h0);
        checkOutput("lu_bubble_rd", RD_E, 5'd0);
        checkOutput("lu_cnt", BubbleCnt, 16'd1);
        checkOutput("lu_cnt_sat", sat_BubbleCnt, 2'd1);
        checkOutput("lu_hazard_clear", HazardStallD, 1'b0);
        stepClk();
        checkOutput("lu_add_valid", ValidE, 1'b1);
        checkOutput("lu_add_rd", RD_E, 5'd7);
        checkOutput("lu_add_rs1", RS1_E, 5'd6);
        checkOutput("lu_add_rs2", RS2_E, 5'd2);
        checkOutput("lu_add_pc", PCE, 32'h114);
        checkOutput("lu_add_cnt", BubbleCnt, 16'd1);

        $display("[TB] stall holds E");
        applyStimulus(1'b1, I_LW_X6, 32'h118, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_hazard", HazardStallD, 1'b0);
            stepClk();
            checkOutput("stall_valid", ValidE, 1'b1);
            checkOutput("stall_rd", RD_E, 5'd7);
            checkOutput("stall_pc", PCE, 32'h114);
            checkOutput("stall_cnt", BubbleCnt, 16'd1);
        end
        applyStimulus(1'b1, I_LW_X6, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("unstall_rd", RD_E, 5'd6);
        checkOutput("unstall_pc", PCE, 32'h118);

        $display("[TB] stalled load keeps hazard high");
        applyStimulus(1'b1, I_ADD_X7, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("held_hazard", HazardStallD, 1'b1);
            stepClk();
            checkOutput("held_rd", RD_E, 5'd6);
            checkOutput("held_pc", PCE, 32'h118);
            checkOutput("held_cnt", BubbleCnt, 16'd1);
        end
        checkOutput("held_hazard_after", HazardStallD, 1'b1);

        $display("[TB] flush with stall and hazard");
        applyStimulus(1'b1, I_ADD_X7, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        stepClk();
        checkOutput("flush_valid", ValidE, 1'b0);
        checkOutput("flush_pc", PCE, 32'h0);
        checkOutput("flush_cnt", BubbleCnt, 16'd2);
        checkOutput("flush_cnt_sat", sat_BubbleCnt, 2'd2);
        checkOutput("flush_hazard", HazardStallD, 1'b0);
        applyStimulus(1'b1, I_ADD_X7, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("reload_valid", ValidE, 1'b1);
        checkOutput("reload_rd", RD_E, 5'd7);
        checkOutput("reload_pc", PCE, 32'h11C);

        $display("[TB] invalid input bubble");
        applyStimulus(1'b0, I_ADD_X7, 32'h120, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("idle_valid", ValidE, 1'b0);
        checkOutput("idle_rd", RD_E, 5'd0);
        checkOutput("idle_cnt", BubbleCnt, 16'd2);
        checkOutput("idle_cnt_sat", sat_BubbleCnt, 2'd2);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, I_ADDI_X5, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("pre_rst_valid", ValidE, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", ValidE, 1'b0);
        checkOutput("arst_rd", RD_E, 5'd0);
        checkOutput("arst_pc", PCE, 32'h0);
        checkOutput("arst_imm", Imm_Ext_E, 32'h0);
        checkOutput("arst_cnt", BubbleCnt, 16'd0);
        checkOutput("arst_cnt_sat", sat_BubbleCnt, 2'd0);
        stepClk();
        rst = 1'b0;
        applyStimulus(1'b1, I_ADD_X8, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        stepClk();
        checkOutput("post_rst_x5", RD1_E, 32'h0);
        checkOutput("post_rst_valid", ValidE, 1'b1);
        checkOutput("post_rst_cnt", BubbleCnt, 16'd0);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, I_ADD_X8, 32'h204, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stepClk();
            checkOutput("sat_flush_valid", ValidE, 1'b0);
            checkOutput("sat_cnt_wide", BubbleCnt, 16'(i + 1));
            checkOutput("sat_cnt_narrow", sat_BubbleCnt, (i + 1 > 3) ? 2'd3 : 2'(i + 1));
        end
        applyStimulus(1'b0, I_ADD_X8, 32'h208, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            stepClk();
            checkOutput("sat_idle_wide", BubbleCnt, 16'd5);
            checkOutput("sat_idle_narrow", sat_BubbleCnt, 2'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
